// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between NUM_REQ requesters, the arbiter and the UART byte controller.
// The arbiter connects through the slave modport; the requester/downstream side uses master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 burst_cut;

  modport slave (
    input  req_data, req_valid, req_last, out_ready,
    output req_ready, out_data, out_valid, grant_id, busy, burst_cut
  );

  modport master (
    output req_data, req_valid, req_last, out_ready,
    input  req_ready, out_data, out_valid, grant_id, busy, burst_cut
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter merging NUM_REQ byte streams onto one UART byte channel, with an
// optional source-ID header per grant and a forced release after MAX_BURST payload bytes.
//
// state  | meaning
// IDLE   | no grant; arbitrate among valid requesters
// HEADER | presenting header byte {4'hA, 1'b0, grant_id}
// STREAM | combinational pass-through of the grantee's bytes
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int HEADER_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, HEADER, STREAM} state_t;

  state_t          state_q, state_d;
  logic [2:0]      grant_q, grant_d;
  logic [2:0]      last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;

  logic [7:0]      data_arr [8];
  logic [7:0]      valid_pad, last_pad, ready_pad;
  logic            found;
  logic [2:0]      pick;
  logic [3:0]      idx;
  logic [7:0]      out_data_c;
  logic            out_valid_c, burst_cut_c;

  // Pad per-requester vectors to 8 so a 3-bit grant index is always in range.
  for (genvar g = 0; g < 8; g++) begin : g_pad
    if (g < NUM_REQ) begin : g_used
      assign data_arr[g]  = bus.req_data[g*8 +: 8];
      assign valid_pad[g] = bus.req_valid[g];
      assign last_pad[g]  = bus.req_last[g];
    end else begin : g_unused
      assign data_arr[g]  = 8'h00;
      assign valid_pad[g] = 1'b0;
      assign last_pad[g]  = 1'b0;
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last_q} + 4'(k);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      if (!found && valid_pad[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 3'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    out_data_c  = 8'h00;
    out_valid_c = 1'b0;
    ready_pad   = '0;
    burst_cut_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          grant_d = pick;
          state_d = (HEADER_EN != 0) ? HEADER : STREAM;
        end
      end
      HEADER: begin
        cnt_d       = '0;
        out_data_c  = {4'hA, 1'b0, grant_q};
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = STREAM;
      end
      STREAM: begin
        out_data_c         = data_arr[grant_q];
        out_valid_c        = valid_pad[grant_q];
        ready_pad[grant_q] = bus.out_ready;
        if (valid_pad[grant_q] && bus.out_ready) begin
          cnt_d = cnt_inc;
          if (last_pad[grant_q]) begin
            state_d = IDLE;
            last_d  = grant_q;
            grant_d = '0;
          end else if (cnt_inc == CW'(MAX_BURST)) begin
            state_d     = IDLE;
            last_d      = grant_q;
            grant_d     = '0;
            burst_cut_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_data  = out_data_c;
  assign bus.out_valid = out_valid_c;
  assign bus.req_ready = ready_pad[NUM_REQ-1:0];
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.burst_cut = burst_cut_c;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed latency/reset scenarios plus queue-based streams
// checked against a transaction-level model of round-robin grants, headers and burst cuts.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus();

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .HEADER_EN(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] b;
    int         id;
    bit         hdr;
    bit         cut;
  } exp_t;

  int         tests = 0;
  int         fails = 0;
  int         model_last;
  exp_t       eq[$];
  logic [7:0] rq_b [NR][$];
  bit         rq_l [NR][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_out_data"},  32'(bus.out_data), 0);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_busy"},      32'(bus.busy), 0);
    chk({tag, "_grant_id"},  32'(bus.grant_id), 0);
    chk({tag, "_burst_cut"}, 32'(bus.burst_cut), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_rst_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    model_last = NR - 1;
  endtask

  task automatic clear_q();
    for (int i = 0; i < NR; i++) begin
      rq_b[i].delete();
      rq_l[i].delete();
    end
  endtask

  task automatic add_frame(input int r, input int len, input logic [7:0] base, input bit rnd);
    for (int j = 0; j < len; j++) begin
      rq_b[r].push_back(rnd ? 8'($urandom) : base + 8'(j));
      rq_l[r].push_back(j == len - 1);
    end
  endtask

  // Expected output byte sequence: round-robin over requesters with pending bytes,
  // one header per grant, up to MB payload bytes per grant.
  task automatic build_model();
    int ptr[NR];
    int pick, n, idx;
    bit any;
    exp_t e;
    for (int i = 0; i < NR; i++) ptr[i] = 0;
    eq.delete();
    forever begin
      any  = 1'b0;
      pick = 0;
      for (int k = 1; k <= NR; k++) begin
        idx = (model_last + k) % NR;
        if (!any && ptr[idx] < rq_b[idx].size()) begin
          any  = 1'b1;
          pick = idx;
        end
      end
      if (!any) break;
      eq.push_back('{8'hA0 | 8'(pick), pick, 1'b1, 1'b0});
      n = 0;
      while (ptr[pick] < rq_b[pick].size()) begin
        e.b   = rq_b[pick][ptr[pick]];
        e.id  = pick;
        e.hdr = 1'b0;
        n++;
        e.cut = !rq_l[pick][ptr[pick]] && (n == MB);
        eq.push_back(e);
        ptr[pick]++;
        if (rq_l[pick][ptr[pick]-1] || n == MB) break;
      end
      model_last = pick;
    end
  endtask

  task automatic run_engine(input string tag, input bit rnd_ready, input bit drops, input int budget);
    bit         held [NR];
    bit         v, acc;
    logic       prev_stall;
    logic [7:0] prev_data;
    int         cyc;
    exp_t       h;
    build_model();
    for (int i = 0; i < NR; i++) held[i] = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    cyc = 0;
    while (eq.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NR; i++) begin
        if (rq_b[i].size() == 0) v = 1'b0;
        else if (held[i]) v = 1'b1;
        else if (drops && !eq[0].hdr && eq[0].id == i && $urandom_range(3) == 0) v = 1'b0;
        else v = 1'b1;
        bus.req_valid[i]       = v;
        bus.req_data[i*8 +: 8] = (rq_b[i].size() > 0) ? rq_b[i][0] : 8'h00;
        bus.req_last[i]        = (rq_l[i].size() > 0) ? rq_l[i][0] : 1'b0;
      end
      bus.out_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
      #1;
      if (prev_stall) begin
        chk({tag, "_stall_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_stall_data"},  32'(bus.out_data), 32'(prev_data));
      end
      if (bus.out_valid && bus.out_ready) begin
        h = eq.pop_front();
        chk({tag, "_byte"},      32'(bus.out_data), 32'(h.b));
        chk({tag, "_burst_cut"}, 32'(bus.burst_cut), 32'(h.cut));
        chk({tag, "_grant_id"},  32'(bus.grant_id), 32'(h.id));
        chk({tag, "_req_ready"}, 32'(bus.req_ready), h.hdr ? 0 : (1 << h.id));
      end else begin
        chk({tag, "_cut_quiet"}, 32'(bus.burst_cut), 0);
      end
      for (int i = 0; i < NR; i++) begin
        acc     = bus.req_valid[i] && bus.req_ready[i];
        held[i] = bus.req_valid[i] && !acc;
        if (acc) begin
          void'(rq_b[i].pop_front());
          void'(rq_l[i].pop_front());
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
    if (eq.size() != 0) chk({tag, "_timeout_left"}, 32'(eq.size()), 0);
    @(negedge clk);
    bus.req_valid = '0;
    bus.req_last  = '0;
    #1;
    chk({tag, "_end_busy"},      32'(bus.busy), 0);
    chk({tag, "_end_out_valid"}, 32'(bus.out_valid), 0);
  endtask

  initial begin
    int nf;
    rst = 1'b1;
    do_reset();

    // Header + 3 bytes from requester 2, one cycle after valid is seen in IDLE.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h0011_0000;
    bus.req_last  = 4'b0000;
    #1 chk("s1_idle_valid", 32'(bus.out_valid), 0);
    chk("s1_idle_busy", 32'(bus.busy), 0);
    @(negedge clk);
    #1 chk("s1_hdr_data", 32'(bus.out_data), 32'hA2);
    chk("s1_hdr_valid", 32'(bus.out_valid), 1);
    chk("s1_hdr_ready", 32'(bus.req_ready), 0);
    chk("s1_hdr_busy", 32'(bus.busy), 1);
    @(negedge clk);
    #1 chk("s1_b1_data", 32'(bus.out_data), 32'h11);
    chk("s1_b1_ready", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    bus.req_data = 32'h0022_0000;
    #1 chk("s1_b2_data", 32'(bus.out_data), 32'h22);
    @(negedge clk);
    bus.req_data = 32'h0033_0000;
    bus.req_last = 4'b0100;
    #1 chk("s1_b3_data", 32'(bus.out_data), 32'h33);
    chk("s1_b3_busy", 32'(bus.busy), 1);
    @(negedge clk);
    bus.req_valid = '0;
    bus.req_last  = '0;
    #1 chk("s1_after_busy", 32'(bus.busy), 0);
    chk("s1_after_valid", 32'(bus.out_valid), 0);
    chk("s1_after_gid", 32'(bus.grant_id), 0);
    model_last = 2;

    // Burst cut: requester 1, 20 bytes, last only on byte 20.
    clear_q();
    add_frame(1, 20, 8'h40, 1'b0);
    run_engine("s3_cut", 1'b0, 1'b0, 200);

    // Round robin over 0,1,3 with one-byte frames from reset.
    do_reset();
    clear_q();
    for (int f = 0; f < 2; f++) begin
      add_frame(0, 1, 8'hC0 + 8'(f), 1'b0);
      add_frame(1, 1, 8'hD0 + 8'(f), 1'b0);
      add_frame(3, 1, 8'hE0 + 8'(f), 1'b0);
    end
    run_engine("s2_rr", 1'b0, 1'b0, 200);

    // Reset asserted while requester 0 is mid-frame.
    do_reset();
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h50;
    #1 chk("s5_idle_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    #1 chk("s5_hdr", 32'(bus.out_data), 32'hA0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bus.req_data = 32'(8'h50 + 8'(j));
      #1 chk("s5_payload", 32'(bus.out_data), 32'(8'h50 + 8'(j)));
    end
    @(negedge clk);
    bus.req_data = 32'h53;
    rst = 1'b1;
    #1 chk_rst_vals("s5_rst");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("s5_post_valid", 32'(bus.out_valid), 0);
    chk("s5_post_busy", 32'(bus.busy), 0);
    @(negedge clk);
    #1 chk("s5_rehdr_data", 32'(bus.out_data), 32'hA0);
    chk("s5_rehdr_valid", 32'(bus.out_valid), 1);

    // Last coincident with the 16th byte, under random backpressure.
    do_reset();
    clear_q();
    add_frame(3, 16, 8'h80, 1'b0);
    add_frame(3, 3, 8'h90, 1'b0);
    run_engine("s6_last16", 1'b1, 1'b0, 400);

    // Randomized traffic with backpressure and grantee valid gaps.
    for (int r = 0; r < 4; r++) begin
      clear_q();
      for (int i = 0; i < NR; i++) begin
        nf = $urandom_range(2);
        for (int f = 0; f < nf; f++) add_frame(i, $urandom_range(1, 20), 8'h00, 1'b1);
      end
      run_engine("rand", 1'b1, 1'b1, 3000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
